// File: rtl/core_int_ctrl_pkg.sv
// Shared encodings for the EMC08 interrupt controller: FSM states, service levels, limits.
package core_int_ctrl_pkg;

    localparam int ICU_MAX_SRC = 8;
    localparam int ICU_VEC_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } icu_state_e;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        LVL_LOW  = 2'd1,
        LVL_HIGH = 2'd2
    } icu_lvl_e;

endpackage

// File: rtl/core_icu_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of i_req and whether any bit is set.
module core_icu_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic [2:0]         o_idx,
    output logic               o_vld
);

    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        // Walk downward so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_vld = 1'b1;
                o_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/core_int_ctrl.sv
// EMC08 interrupt controller: pending latch, level/index arbitration, request handshake, nesting.
// Define ICU_NESTING_EN for two priority levels with preemption; otherwise one level, no nesting.
module core_int_ctrl
    import core_int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               icu_clock_i,
    input  logic               icu_reset_i,
    input  logic [NUM_SRC-1:0] icu_src_i,
    input  logic [NUM_SRC-1:0] icu_edge_i,
    input  logic [NUM_SRC-1:0] icu_en_i,
    input  logic               icu_global_en_i,
    input  logic [NUM_SRC-1:0] icu_prio_i,
    input  logic [NUM_SRC-1:0] icu_clr_i,
    input  logic               icu_int_ack_i,
    input  logic               icu_int_ret_i,
    output logic               icu_req_o,
    output logic [2:0]         icu_vect_o,
    output logic [NUM_SRC-1:0] icu_pending_o,
    output logic [1:0]         icu_active_o
);

    icu_state_e               r_state, w_state_nxt;
    icu_lvl_e                 r_lvl, w_cur_lvl, w_win_lvl;
    logic [NUM_SRC-1:0]       r_src_q, r_pend_edge;
    logic [2:0]               r_vect;
    logic [1:0]               r_active, w_active_nxt;
    logic                     r_req;

    logic [NUM_SRC-1:0]       w_pend, w_src_hi, w_elig_base, w_elig_hi, w_elig_lo;
    logic [ICU_MAX_SRC-1:0]   w_elig_x, w_ack_oh;
    logic [2:0]               w_hi_idx, w_lo_idx, w_win_idx;
    logic                     w_hi_vld, w_lo_vld, w_win_vld, w_ack, w_latch;

`ifdef ICU_NESTING_EN
    assign w_src_hi = icu_prio_i;
`else
    logic w_unused_prio;
    assign w_unused_prio = ^icu_prio_i;
    assign w_src_hi      = '0;
`endif

    assign w_pend      = (icu_edge_i & r_pend_edge) | (~icu_edge_i & icu_src_i);
    assign w_cur_lvl   = r_active[1] ? LVL_HIGH : (r_active[0] ? LVL_LOW : LVL_NONE);
    assign w_elig_base = w_pend & icu_en_i & {NUM_SRC{icu_global_en_i}};
    // A source competes only if its level is strictly above what is already in service.
    assign w_elig_hi   = w_elig_base &  w_src_hi & {NUM_SRC{w_cur_lvl != LVL_HIGH}};
    assign w_elig_lo   = w_elig_base & ~w_src_hi & {NUM_SRC{w_cur_lvl == LVL_NONE}};
    assign w_elig_x    = ICU_MAX_SRC'(w_elig_hi | w_elig_lo);

    core_icu_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc_hi (
        .i_req (w_elig_hi),
        .o_idx (w_hi_idx),
        .o_vld (w_hi_vld)
    );

    core_icu_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc_lo (
        .i_req (w_elig_lo),
        .o_idx (w_lo_idx),
        .o_vld (w_lo_vld)
    );

    assign w_win_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    assign w_win_lvl = w_hi_vld ? LVL_HIGH : LVL_LOW;
    assign w_win_vld = w_hi_vld | w_lo_vld;
    assign w_ack     = (r_state == ST_REQ) & icu_int_ack_i;

    // An ack in REQ commits the vector even if eligibility drops in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_win_vld) begin
                w_state_nxt = ST_REQ;
                w_latch     = 1'b1;
            end
            ST_REQ: begin
                if (icu_int_ack_i)          w_state_nxt = ST_HOLD;
                else if (!w_elig_x[r_vect]) w_state_nxt = ST_IDLE;
            end
            ST_HOLD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ack_oh     = '0;
        w_active_nxt = r_active;
        if (w_ack) w_ack_oh[r_vect] = 1'b1;
        // RETI retires the highest in-service level before the ack adds its own.
        if (icu_int_ret_i) begin
            if (w_active_nxt[1]) w_active_nxt[1] = 1'b0;
            else                 w_active_nxt[0] = 1'b0;
        end
        if (w_ack) begin
            if (r_lvl == LVL_HIGH) w_active_nxt[1] = 1'b1;
            else                   w_active_nxt[0] = 1'b1;
        end
    end

    always_ff @(posedge icu_clock_i) begin
        if (icu_reset_i) begin
            r_state     <= ST_IDLE;
            r_lvl       <= LVL_NONE;
            r_src_q     <= '0;
            r_pend_edge <= '0;
            r_vect      <= '0;
            r_active    <= '0;
            r_req       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_src_q     <= icu_src_i;
            r_req       <= (w_state_nxt == ST_REQ);
            r_active    <= w_active_nxt;
            r_pend_edge <= icu_edge_i & ((icu_src_i & ~r_src_q) |
                           (r_pend_edge & ~icu_clr_i & ~w_ack_oh[NUM_SRC-1:0]));
            if (w_latch) begin
                r_vect <= w_win_idx;
                r_lvl  <= w_win_lvl;
            end
        end
    end

    assign icu_req_o     = r_req;
    assign icu_vect_o    = r_vect;
    assign icu_pending_o = w_pend;
`ifdef ICU_NESTING_EN
    assign icu_active_o  = r_active;
`else
    assign icu_active_o  = {1'b0, r_active[0]};
`endif

endmodule

// File: tb/tb_core_int_ctrl.sv
// Bench for core_int_ctrl: directed table, corner sequences and a randomized run against a rule model.
module tb_core_int_ctrl;

    localparam int N = 8;
`ifdef ICU_NESTING_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, ea, ack, ret;
    logic [N-1:0] src, edg, en, prio, clr;
    logic         req;
    logic [2:0]   vect;
    logic [N-1:0] pend;
    logic [1:0]   act;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    core_int_ctrl #(.NUM_SRC(N)) dut (
        .icu_clock_i     (clk),
        .icu_reset_i     (rst),
        .icu_src_i       (src),
        .icu_edge_i      (edg),
        .icu_en_i        (en),
        .icu_global_en_i (ea),
        .icu_prio_i      (prio),
        .icu_clr_i       (clr),
        .icu_int_ack_i   (ack),
        .icu_int_ret_i   (ret),
        .icu_req_o       (req),
        .icu_vect_o      (vect),
        .icu_pending_o   (pend),
        .icu_active_o    (act)
    );

    // Reference model: phase 0 = waiting, 1 = requesting, 2 = vector fetch gap.
    bit m_pe[N];
    bit m_sq[N];
    bit m_hi, m_lo;
    int m_phase, m_vect, m_lvl;

    function automatic int lvl_of(int i);
        return (NEST && prio[i]) ? 2 : 1;
    endfunction

    function automatic bit elig(int i);
        int cur = m_hi ? 2 : (m_lo ? 1 : 0);
        bit p   = edg[i] ? m_pe[i] : src[i];
        return p && en[i] && ea && (lvl_of(i) > cur);
    endfunction

    task automatic model_step();
        int best = -1;
        bit keep, ackd;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_pe[i] = 0; m_sq[i] = 0; end
            m_hi = 0; m_lo = 0; m_phase = 0; m_vect = 0; m_lvl = 0;
            return;
        end
        for (int i = 0; i < N; i++)
            if (elig(i) && (best < 0 || lvl_of(i) > lvl_of(best))) best = i;
        keep = elig(m_vect);
        ackd = (m_phase == 1) && ack;
        if (ret) begin
            if (m_hi) m_hi = 0; else m_lo = 0;
        end
        if (ackd) begin
            if (m_lvl == 2) m_hi = 1; else m_lo = 1;
        end
        for (int i = 0; i < N; i++) begin
            bit rise = src[i] && !m_sq[i];
            bit kill = clr[i] || (ackd && m_vect == i);
            m_pe[i] = edg[i] && (rise || (m_pe[i] && !kill));
            m_sq[i] = src[i];
        end
        case (m_phase)
            0: if (best >= 0) begin m_phase = 1; m_vect = best; m_lvl = lvl_of(best); end
            1: if (ack) m_phase = 2; else if (!keep) m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic tick();
        logic [N-1:0] ep;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) ep[i] = edg[i] ? m_pe[i] : src[i];
        chk("model_req",    int'(req),  int'(m_phase == 1));
        chk("model_vect",   int'(vect), m_vect);
        chk("model_pend",   int'(pend), int'(ep));
        chk("model_active", int'(act),  int'({m_hi, m_lo}));
    endtask

    task automatic quiet();
        src = '0; clr = '0; ack = 0; ret = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic pulse_ack();
        ack = 1; tick(); ack = 0;
    endtask

    task automatic pulse_ret();
        ret = 1; tick(); ret = 0;
    endtask

    task automatic wait_req(int bound);
        int n = 0;
        while (!req && n < bound) begin tick(); n++; end
        chk("wait_req", int'(req), 1);
    endtask

    typedef struct {
        logic [7:0] src;
        bit         ack;
        bit         ret;
        bit         e_req;
        logic [2:0] e_vect;
        logic [1:0] e_act;
        logic [7:0] e_pend;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // Single edge source on bit 2: pulse, request, ack, RETI.
        tbl[0] = '{8'h04, 0, 0, 0, 3'd0, 2'b00, 8'h04};
        tbl[1] = '{8'h00, 0, 0, 1, 3'd2, 2'b00, 8'h04};
        tbl[2] = '{8'h00, 1, 0, 0, 3'd2, 2'b01, 8'h00};
        tbl[3] = '{8'h00, 0, 0, 0, 3'd2, 2'b01, 8'h00};
        tbl[4] = '{8'h00, 0, 1, 0, 3'd2, 2'b00, 8'h00};
        tbl[5] = '{8'h00, 0, 0, 0, 3'd2, 2'b00, 8'h00};

        edg = '0; en = '0; prio = '0; ea = 0;
        do_reset();
        chk("rst_req", int'(req), 0);
        chk("rst_vect", int'(vect), 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_active", int'(act), 0);

        ea = 1; en = 8'h04; edg = 8'h04;
        foreach (tbl[k]) begin
            src = tbl[k].src; ack = tbl[k].ack; ret = tbl[k].ret;
            tick();
            chk($sformatf("tbl%0d_req", k), int'(req), int'(tbl[k].e_req));
            chk($sformatf("tbl%0d_vect", k), int'(vect), int'(tbl[k].e_vect));
            chk($sformatf("tbl%0d_active", k), int'(act), int'(tbl[k].e_act));
            chk($sformatf("tbl%0d_pend", k), int'(pend), int'(tbl[k].e_pend));
        end
        quiet();

        // Simultaneous low sources 5 and 1: index 1 first, then 5 after RETI.
        do_reset();
        en = 8'hFF; edg = 8'hFF; prio = '0;
        src = 8'h22; tick(); src = '0;
        wait_req(4);
        chk("simul_first", int'(vect), 1);
        pulse_ack(); tick();
        chk("simul_blocked", int'(req), 0);
        pulse_ret();
        wait_req(4);
        chk("simul_second", int'(vect), 5);
        pulse_ack(); tick(); pulse_ret();

        // Preemption: low source 3 in service, high source 6 arrives.
        do_reset();
        prio = 8'h40;
        src = 8'h08; tick(); src = '0;
        wait_req(4);
        chk("pre_low_vect", int'(vect), 3);
        pulse_ack(); tick();
        chk("pre_low_active", int'(act), 1);
        src = 8'h40; tick(); src = '0;
        if (NEST) begin
            wait_req(4);
            chk("pre_high_vect", int'(vect), 6);
            pulse_ack();
            chk("pre_nest_active", int'(act), 3);
            tick(); pulse_ret();
            chk("pre_ret1", int'(act), 1);
            pulse_ret();
            chk("pre_ret2", int'(act), 0);
        end else begin
            repeat (5) tick();
            chk("pre_blocked", int'(req), 0);
            pulse_ret();
            wait_req(4);
            chk("pre_after_ret", int'(vect), 6);
            pulse_ack(); tick(); pulse_ret();
        end

        // Ack and RETI together while one level is already in service.
        do_reset();
        src = 8'h08; tick(); src = '0;
        wait_req(4); pulse_ack(); tick();
        src = 8'h40; tick(); src = '0;
        if (NEST) wait_req(4); else tick();
        ack = 1; ret = 1; tick(); ack = 0; ret = 0;
        chk("ack_ret_active", int'(act), NEST ? 2 : 0);
        tick(); repeat (2) pulse_ret();
        // When nesting is off source 6 is still pending; drain it.
        if (!NEST) begin wait_req(4); pulse_ack(); tick(); pulse_ret(); end

        // Withdrawal: level source 0 drops before ack.
        do_reset();
        edg = 8'h00; en = 8'h01; prio = '0;
        src = 8'h01;
        wait_req(4);
        chk("wd_vect_req", int'(vect), 0);
        src = '0; tick();
        chk("wd_req", int'(req), 0);
        chk("wd_active", int'(act), 0);
        tick();

        // Software clear racing a new edge on the same bit: set wins.
        do_reset();
        edg = 8'h10; en = 8'h00;
        src = 8'h10; tick(); src = '0; tick();
        src = 8'h10; clr = 8'h10; tick(); clr = '0;
        chk("clr_vs_set", int'(pend), 8'h10);
        src = '0; clr = 8'h10; tick(); clr = '0;
        chk("clr_only", int'(pend), 8'h00);

        // Reset while a request is outstanding.
        do_reset();
        en = 8'hFF; edg = 8'hFF;
        src = 8'h80; tick(); src = '0;
        wait_req(4);
        rst = 1; tick(); rst = 0;
        chk("rst_req_mid", int'(req), 0);
        chk("rst_vect_mid", int'(vect), 0);
        chk("rst_pend_mid", int'(pend), 0);
        chk("rst_act_mid", int'(act), 0);

        // Randomized traffic checked against the model every cycle.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                edg  = N'($urandom);
                prio = N'($urandom);
            end
            en  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            ea  = ($urandom_range(0, 15) != 0);
            src = src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            clr = ($urandom_range(0, 7) == 0) ? (N'($urandom) & N'($urandom)) : '0;
            ack = ($urandom_range(0, 2) == 0);
            ret = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 0;
        quiet();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
